// File: rtl/cache_line_mover_pkg.sv
// Shared constants and FSM state encoding for the cache line mover.
//   SET_W  : data-array row address width
//   LINE_W : cache line width in bits
//   BEAT_W : memory burst beat width
//   BEATS  : beats per line (LINE_W / BEAT_W)
package cache_line_mover_pkg;

    localparam int SET_W  = 5;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;

    typedef enum logic [2:0] {
        IDLE,
        FILL_REQ,
        FILL_RX,
        FILL_WR,
        WB_RD,
        WB_CAP,
        WB_TX,
        DONE
    } state_t;

endpackage

// File: rtl/cache_line_buf.sv
// Line staging buffer, organised as beats.
//   clk, rst   : clock, async active-high reset (clears the buffer)
//   beat_we    : write beat_data into beat slot beat_idx
//   line_we    : load the whole line from line_data (wins over beat_we)
//   line       : current buffer contents, beat 0 in the low bits
module cache_line_buf
    import cache_line_mover_pkg::*;
#(
    parameter int LINE_W = cache_line_mover_pkg::LINE_W,
    parameter int BEAT_W = cache_line_mover_pkg::BEAT_W,
    localparam int NBEATS = LINE_W / BEAT_W,
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           beat_we,
    input  logic [IDX_W-1:0]               beat_idx,
    input  logic [BEAT_W-1:0]              beat_data,
    input  logic                           line_we,
    input  logic [LINE_W-1:0]              line_data,
    output logic [NBEATS-1:0][BEAT_W-1:0]  line
);

    for (genvar g = 0; g < NBEATS; g++) begin : g_beat
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                line[g] <= '0;
            end else if (line_we) begin
                line[g] <= line_data[g*BEAT_W +: BEAT_W];
            end else if (beat_we && (beat_idx == IDX_W'(g))) begin
                line[g] <= beat_data;
            end
        end
    end

endmodule

// File: rtl/cache_line_mover.sv
// Moves one cache line between the data array and burst memory.
//   req_*  : request handshake (write=1 writeback array->memory, 0 fill)
//   done   : one-cycle completion pulse
//   arr_*  : single-port data array, active-low select/write, 1-cycle read
//   mem_*  : burst memory, one address per line, BEATS beats low beat first
// All array/memory outputs decode from the state register and registered
// fields only, so no input reaches arr_* or mem_* combinationally.
module cache_line_mover
    import cache_line_mover_pkg::*;
#(
    parameter int SET_W  = cache_line_mover_pkg::SET_W,
    parameter int LINE_W = cache_line_mover_pkg::LINE_W,
    parameter int BEAT_W = cache_line_mover_pkg::BEAT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [SET_W-1:0]    req_set,
    input  logic [31:0]         req_addr,
    output logic                done,
    output logic                arr_csb,
    output logic                arr_web,
    output logic [LINE_W/8-1:0] arr_wmask,
    output logic [SET_W-1:0]    arr_addr,
    output logic [LINE_W-1:0]   arr_din,
    input  logic [LINE_W-1:0]   arr_dout,
    output logic [31:0]         mem_addr,
    output logic                mem_read,
    output logic                mem_write,
    output logic [BEAT_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [BEAT_W-1:0]   mem_rdata,
    input  logic                mem_rvalid
);

    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBEATS - 1);

    state_t                          state, state_n;
    logic [IDX_W-1:0]                cnt;
    logic                            cnt_inc;
    logic                            lat_write;
    logic [SET_W-1:0]                lat_set;
    logic [31:0]                     lat_addr;
    logic                            accept;
    logic                            beat_we;
    logic                            line_we;
    logic [NBEATS-1:0][BEAT_W-1:0]   line_q;

    cache_line_buf #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .beat_we   (beat_we),
        .beat_idx  (cnt),
        .beat_data (mem_rdata),
        .line_we   (line_we),
        .line_data (arr_dout),
        .line      (line_q)
    );

    assign accept    = req_valid && req_ready;
    assign arr_addr  = lat_set;
    assign arr_din   = line_q;
    assign mem_addr  = lat_addr;
    assign mem_wdata = line_q[cnt];

    // The beat counter wraps back to 0 after the last beat of every burst,
    // so it needs no explicit clear between moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_set   <= '0;
            lat_addr  <= '0;
        end else begin
            state <= state_n;
            if (cnt_inc) cnt <= cnt + 1'b1;
            if (accept) begin
                lat_write <= req_write;
                lat_set   <= req_set;
                lat_addr  <= req_addr;
            end
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        done      = 1'b0;
        arr_csb   = 1'b1;
        arr_web   = 1'b1;
        arr_wmask = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        beat_we   = 1'b0;
        line_we   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = req_write ? WB_RD : FILL_REQ;
            end
            FILL_REQ: begin
                mem_read = 1'b1;
                if (mem_ready) state_n = FILL_RX;
            end
            FILL_RX: begin
                if (mem_rvalid) begin
                    beat_we = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt == LAST) state_n = FILL_WR;
                end
            end
            FILL_WR: begin
                arr_csb   = 1'b0;
                arr_web   = 1'b0;
                arr_wmask = '1;
                state_n   = DONE;
            end
            WB_RD: begin
                arr_csb = 1'b0;
                state_n = WB_CAP;
            end
            WB_CAP: begin
                // Array data from the WB_RD read is valid this cycle.
                line_we = 1'b1;
                state_n = WB_TX;
            end
            WB_TX: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    cnt_inc = 1'b1;
                    if (cnt == LAST) state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_line_mover.sv
module tb_cache_line_mover;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_write;
    logic [4:0]   req_set;
    logic [31:0]  req_addr;
    logic         done;
    logic         arr_csb, arr_web;
    logic [31:0]  arr_wmask;
    logic [4:0]   arr_addr;
    logic [255:0] arr_din, arr_dout;
    logic [31:0]  mem_addr;
    logic         mem_read, mem_write, mem_ready, mem_rvalid;
    logic [63:0]  mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_fail = 0;

    // Observation counters, written only by the monitor.
    int acc_cnt = 0;
    int done_cnt = 0;
    int arr_wr_cnt = 0;
    logic [63:0] wq[$];

    logic [255:0] arr_mem [32];
    logic         pre_we;
    logic [4:0]   pre_addr;
    logic [255:0] pre_data;

    always #5 clk = ~clk;

    cache_line_mover dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_set(req_set), .req_addr(req_addr), .done(done),
        .arr_csb(arr_csb), .arr_web(arr_web), .arr_wmask(arr_wmask),
        .arr_addr(arr_addr), .arr_din(arr_din), .arr_dout(arr_dout),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid)
    );

    // Data array: registered byte-masked write, one-cycle read latency.
    always @(posedge clk) begin
        if (pre_we) arr_mem[pre_addr] <= pre_data;
        if (!arr_csb) begin
            if (!arr_web) begin
                for (int b = 0; b < 32; b++)
                    if (arr_wmask[b]) arr_mem[arr_addr][b*8 +: 8] <= arr_din[b*8 +: 8];
            end else begin
                arr_dout <= arr_mem[arr_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (!arr_csb && !arr_web) arr_wr_cnt <= arr_wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (mem_write && mem_ready) wq.push_back(mem_wdata);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [4:0] set, input logic [31:0] addr, input logic [255:0] line,
                        input int rdy_dly, input int gap, input bit stray);
        int a0, d0, w0;
        a0 = acc_cnt; d0 = done_cnt; w0 = arr_wr_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_set = set; req_addr = addr;
        chk("fill_accept_rdy", 256'(req_ready), 256'd1);
        tick();
        req_valid = 1'b0; req_set = '0; req_addr = '0;
        repeat (rdy_dly) begin
            chk("fill_req_rd", 256'(mem_read), 256'd1);
            chk("fill_req_addr", 256'(mem_addr), 256'(addr));
            tick();
        end
        mem_ready = 1'b1;
        chk("fill_req_rd", 256'(mem_read), 256'd1);
        chk("fill_req_addr", 256'(mem_addr), 256'(addr));
        tick();
        mem_ready = 1'b0;
        chk("fill_rx_rd_off", 256'(mem_read), 256'd0);
        if (stray) begin req_valid = 1'b1; req_set = 5'd31; req_addr = 32'hBAD0; end
        for (int k = 0; k < 4; k++) begin
            repeat (gap) begin
                mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                chk("fill_rx_rdy", 256'(req_ready), 256'd0);
                tick();
            end
            mem_rvalid = 1'b1; mem_rdata = line[k*64 +: 64];
            tick();
            mem_rvalid = 1'b0; mem_rdata = '0;
        end
        req_valid = 1'b0; req_set = '0; req_addr = '0;
        chk("fill_wr_csb", 256'(arr_csb), 256'd0);
        chk("fill_wr_web", 256'(arr_web), 256'd0);
        chk("fill_wr_mask", 256'(arr_wmask), 256'hFFFF_FFFF);
        chk("fill_wr_addr", 256'(arr_addr), 256'(set));
        chk("fill_wr_din", arr_din, line);
        tick();
        chk("fill_done", 256'(done), 256'd1);
        chk("fill_done_csb", 256'(arr_csb), 256'd1);
        tick();
        chk("fill_done_drop", 256'(done), 256'd0);
        chk("fill_idle_rdy", 256'(req_ready), 256'd1);
        chk("fill_accepts", 256'(acc_cnt - a0), 256'd1);
        chk("fill_dones", 256'(done_cnt - d0), 256'd1);
        chk("fill_arr_writes", 256'(arr_wr_cnt - w0), 256'd1);
        chk("fill_arr_row", arr_mem[set], line);
    endtask

    task automatic wb(input logic [4:0] set, input logic [31:0] addr, input logic [255:0] line,
                      input int stall);
        int d0, q0;
        d0 = done_cnt; q0 = wq.size();
        req_valid = 1'b1; req_write = 1'b1; req_set = set; req_addr = addr;
        chk("wb_accept_rdy", 256'(req_ready), 256'd1);
        tick();
        req_valid = 1'b0; req_write = 1'b0; req_set = '0; req_addr = '0;
        mem_ready = 1'b1;  // must be ignored outside WB_TX
        chk("wb_rd_csb", 256'(arr_csb), 256'd0);
        chk("wb_rd_web", 256'(arr_web), 256'd1);
        chk("wb_rd_addr", 256'(arr_addr), 256'(set));
        chk("wb_rd_nowr", 256'(mem_write), 256'd0);
        tick();
        chk("wb_cap_csb", 256'(arr_csb), 256'd1);
        chk("wb_cap_nowr", 256'(mem_write), 256'd0);
        mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            repeat (stall) begin
                chk("wb_tx_wr", 256'(mem_write), 256'd1);
                chk("wb_tx_addr", 256'(mem_addr), 256'(addr));
                chk("wb_tx_hold", 256'(mem_wdata), 256'(line[k*64 +: 64]));
                tick();
            end
            mem_ready = 1'b1;
            chk("wb_tx_wr", 256'(mem_write), 256'd1);
            chk("wb_tx_data", 256'(mem_wdata), 256'(line[k*64 +: 64]));
            tick();
            mem_ready = 1'b0;
        end
        chk("wb_done", 256'(done), 256'd1);
        chk("wb_done_nowr", 256'(mem_write), 256'd0);
        tick();
        chk("wb_done_drop", 256'(done), 256'd0);
        chk("wb_nbeats", 256'(wq.size() - q0), 256'd4);
        for (int k = 0; k < 4; k++)
            if (q0 + k < wq.size()) chk("wb_beat_q", 256'(wq[q0+k]), 256'(line[k*64 +: 64]));
        chk("wb_dones", 256'(done_cnt - d0), 256'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l1, l3, l4, l5, a5;
        int d0, w0;
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        l3 = {64'h0F0E_0D0C_0B0A_0908, 64'h0706_0504_0302_0100,
              64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        l4 = {64'hCAFE_0004_CAFE_0004, 64'hCAFE_0003_CAFE_0003,
              64'hCAFE_0002_CAFE_0002, 64'hCAFE_0001_CAFE_0001};
        l5 = {64'h5555_AAAA_0000_FFFF, 64'h1234_0000_0000_4321,
              64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE};
        a5 = {32{8'hA5}};

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_set = '0; req_addr = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        pre_we = 1'b1; pre_addr = 5'd7; pre_data = a5;
        tick();
        pre_we = 1'b0;
        tick();
        chk("rst_csb", 256'(arr_csb), 256'd1);
        chk("rst_web", 256'(arr_web), 256'd1);
        chk("rst_mask", 256'(arr_wmask), 256'd0);
        chk("rst_mem_rd", 256'(mem_read), 256'd0);
        chk("rst_mem_wr", 256'(mem_write), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_buf", arr_din, 256'd0);
        rst = 1'b0;
        tick();

        // Basic fill, memory ready on the second request cycle.
        fill(5'd5, 32'h0000_1000, l1, 1, 0, 1'b0);

        // Stray rvalid/ready in IDLE must not touch the buffer.
        mem_rvalid = 1'b1; mem_ready = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
        repeat (3) tick();
        mem_rvalid = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        chk("stray_buf", arr_din, l1);
        chk("stray_idle", 256'(req_ready), 256'd1);
        chk("stray_no_rd", 256'(mem_read), 256'd0);

        // Writeback of a preloaded row.
        wb(5'd7, 32'h0000_2000, a5, 0);

        // Backpressure everywhere plus a stray request during FILL_RX.
        fill(5'd10, 32'h0000_4000, l3, 3, 2, 1'b1);
        wb(5'd10, 32'h0000_4040, l3, 3);

        // Reset after beat 2 of a fill abandons it.
        d0 = done_cnt; w0 = arr_wr_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_set = 5'd9; req_addr = 32'h3000;
        tick();
        req_valid = 1'b0; req_set = '0; req_addr = '0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'h9999_0000_0000_0000 | 64'(k);
            tick();
        end
        mem_rvalid = 1'b0; mem_rdata = '0;
        rst = 1'b1;
        #1;
        chk("mid_rst_idle", 256'(req_ready), 256'd1);
        chk("mid_rst_csb", 256'(arr_csb), 256'd1);
        chk("mid_rst_buf", arr_din, 256'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("mid_rst_no_done", 256'(done_cnt - d0), 256'd0);
        chk("mid_rst_no_wr", 256'(arr_wr_cnt - w0), 256'd0);
        fill(5'd9, 32'h0000_3000, l4, 0, 1, 1'b0);

        // Fill then writeback requested the cycle after done.
        fill(5'd3, 32'h0000_5000, l5, 2, 0, 1'b0);
        wb(5'd3, 32'h0000_6000, l5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
